instr_fetch_unit: RTL

Fetch stage directly downstream of the program counter. It takes the current PC address and issues one instruction-memory read at a time over a req/ready + rvalid handshake. Returned words go into a small in-order buffer toward decode. The block also generates the PC advance strobe: a pulse on each accepted fetch or redirect.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_buffer.sv | 70 +++++++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage: data width, fetch FSM states
// and the canonical bubble encoding.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0; decode treats an invalid head as this bubble.
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic {
        FS_REQ,
        FS_WAIT
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// In-order circular buffer of {instruction, pc} pairs between fetch and decode.
// Flush empties it at the next edge and overrides any push or pop that cycle.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [XLEN-1:0]        push_instr,
    input  logic [XLEN-1:0]        push_pc,
    input  logic                   pop,
    input  logic                   flush,
    output logic [XLEN-1:0]        head_instr,
    output logic [XLEN-1:0]        head_pc,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == DEPTH_C);
    assign head_instr = instr_mem[rd_ptr_q];
    assign head_pc    = pc_mem[rd_ptr_q];

    // Push into a full buffer is legal only when the head leaves the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                instr_mem[wr_ptr_q] <= push_instr;
                pc_mem[wr_ptr_q]    <= push_pc;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem read at a time, responses buffered in order
// toward decode, and the PC advance strobe on each accepted fetch or redirect.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter bit          RESET_DROP = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_addr,
    output logic            inc_pc,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            dec_ready,
    output logic            fetch_busy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            drop_q, drop_d;
    // Holds request/strobe outputs low until the first edge after reset release.
    logic            run_q;

    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_fetch_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_instr (imem_rdata),
        .push_pc    (req_pc_q),
        .pop        (pop),
        .flush      (flush),
        .head_instr (instr),
        .head_pc    (instr_pc),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    assign imem_addr   = {pc_addr[XLEN-1:2], 2'b00};
    assign instr_valid = !empty;
    assign pop         = instr_valid && dec_ready;
    assign fetch_busy  = (state_q == FS_WAIT);

    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        imem_req = 1'b0;
        push     = 1'b0;

        case (state_q)
            FS_REQ: begin
                imem_req = run_q && !flush && (count < DEPTH_C);
                if (imem_req && imem_ready) begin
                    state_d  = FS_WAIT;
                    req_pc_d = pc_addr;
                end
            end
            FS_WAIT: begin
                if (flush) begin
                    // A response still in flight belongs to the old path.
                    if (imem_rvalid) begin
                        state_d = FS_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    state_d = FS_REQ;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            default: state_d = FS_REQ;
        endcase

        inc_pc = run_q && ((imem_req && imem_ready) || flush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FS_REQ;
            req_pc_q <= '0;
            drop_q   <= RESET_DROP;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            run_q    <= 1'b1;
        end
    end

    // Requests are gated on free space, so a response never meets a full buffer.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop && !flush));

endmodule
